// File: rtl/sva_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : sva_stim_gen
// Purpose  : Stimulus generator for the SVA checker of property
//            "c&&b |-> done; !c |-> lazy; c&&a&&!b ##1 b |-> done".
//            Accepts a command (mode + repeat count). Each 'step' pulse is one
//            checker clock edge. On that edge it registers new a/b/c values and
//            the expected succ/fail/lazy verdict from a built-in reference model.
// Ports    : sys_clk/sys_rst      clock, synchronous active-high reset
//            step                 one checker clock edge per pulse
//            cmd_valid/ready      command handshake (ready only in IDLE)
//            cmd_mode/cmd_len     pattern select and repeat count
//            a, b, c              registered stimulus
//            exp_succ/fail/lazy   expected verdict, one cycle after a step
//            busy, done           command in progress / finished pulse
//            succ/fail/lazy_cnt   saturating totals of exp_* pulses
// Revision : 1.0  initial release
// ============================================================================
module sva_stim_gen #(
  parameter int          LEN_W = 8,
  parameter int          CNT_W = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             step,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             exp_succ,
  output logic             exp_fail,
  output logic             exp_lazy,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] succ_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] lazy_cnt
);

  localparam logic [2:0] MODE_PASS1  = 3'd0;
  localparam logic [2:0] MODE_PASS2  = 3'd2;
  localparam logic [2:0] MODE_FAIL0  = 3'd3;
  localparam logic [2:0] MODE_FAIL1  = 3'd4;
  localparam logic [2:0] MODE_RANDOM = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN_A = 2'd1,
    ST_RUN_B = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [LEN_W-1:0] rep_q, rep_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             pend_q, pend_d;
  logic             a_q, a_d, b_q, b_d, c_q, c_d;
  logic             exp_succ_q, exp_succ_d;
  logic             exp_fail_q, exp_fail_d;
  logic             exp_lazy_q, exp_lazy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] succ_cnt_q, succ_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0] lazy_cnt_q, lazy_cnt_d;

  // Values that will be driven if a step occurs this cycle
  logic drv_a, drv_b, drv_c;
  logic two_step;
  logic use_lfsr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    rep_d      = rep_q;
    lfsr_d     = lfsr_q;
    pend_d     = pend_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    exp_succ_d = 1'b0;
    exp_fail_d = 1'b0;
    exp_lazy_d = 1'b0;
    done_d     = (state_q == ST_DONE);
    succ_cnt_d = succ_cnt_q;
    fail_cnt_d = fail_cnt_q;
    lazy_cnt_d = lazy_cnt_q;
    drv_a      = 1'b0;
    drv_b      = 1'b0;
    drv_c      = 1'b0;
    two_step   = 1'b0;
    use_lfsr   = 1'b0;

    // Pattern decode; IDLE and DONE leave the all-zero drive
    case (state_q)
      ST_RUN_A: begin
        case (mode_q)
          MODE_PASS1: begin drv_c = 1'b1; drv_b = 1'b1; end
          MODE_FAIL0: drv_c = 1'b1;
          MODE_PASS2, MODE_FAIL1: begin
            drv_c    = 1'b1;
            drv_a    = 1'b1;
            two_step = 1'b1;
          end
          MODE_RANDOM: begin
            {drv_a, drv_b, drv_c} = lfsr_q[2:0];
            use_lfsr = 1'b1;
            // Random pattern that opens a two-cycle attempt gets its second step
            two_step = lfsr_q[0] & lfsr_q[2] & ~lfsr_q[1];
          end
          default: ; // LAZY (1, 6, 7): all zero
        endcase
      end
      ST_RUN_B: begin
        case (mode_q)
          MODE_PASS2: drv_b = 1'b1;
          MODE_RANDOM: begin
            {drv_a, drv_b, drv_c} = lfsr_q[2:0];
            use_lfsr = 1'b1;
          end
          default: ; // FAIL1: all zero
        endcase
      end
      default: ;
    endcase

    // Command accept is independent of step; a coincident step drives IDLE values
    if (state_q == ST_IDLE && cmd_valid) begin
      mode_d  = cmd_mode;
      rep_d   = cmd_len;
      state_d = (cmd_len != '0) ? ST_RUN_A : ST_DONE;
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end

    if (step) begin
      a_d = drv_a;
      b_d = drv_b;
      c_d = drv_c;
      if (use_lfsr) begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end

      // Outstanding two-cycle attempt resolves on this step's b
      if (pend_q) begin
        if (drv_b) exp_succ_d = 1'b1;
        else       exp_fail_d = 1'b1;
      end
      // New attempt starting at this step
      pend_d = 1'b0;
      if (drv_c && drv_b)  exp_succ_d = 1'b1;
      else if (!drv_c)     exp_lazy_d = 1'b1;
      else if (drv_a)      pend_d     = 1'b1;
      else                 exp_fail_d = 1'b1;

      succ_cnt_d = sat_inc(succ_cnt_q, exp_succ_d);
      fail_cnt_d = sat_inc(fail_cnt_q, exp_fail_d);
      lazy_cnt_d = sat_inc(lazy_cnt_q, exp_lazy_d);

      if ((state_q == ST_RUN_A && !two_step) || state_q == ST_RUN_B) begin
        rep_d   = rep_q - LEN_W'(1);
        state_d = (rep_q == LEN_W'(1)) ? ST_DONE : ST_RUN_A;
      end else if (state_q == ST_RUN_A) begin
        state_d = ST_RUN_B;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= 3'd0;
      rep_q      <= '0;
      lfsr_q     <= SEED;
      pend_q     <= 1'b0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      c_q        <= 1'b0;
      exp_succ_q <= 1'b0;
      exp_fail_q <= 1'b0;
      exp_lazy_q <= 1'b0;
      done_q     <= 1'b0;
      succ_cnt_q <= '0;
      fail_cnt_q <= '0;
      lazy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      rep_q      <= rep_d;
      lfsr_q     <= lfsr_d;
      pend_q     <= pend_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      exp_succ_q <= exp_succ_d;
      exp_fail_q <= exp_fail_d;
      exp_lazy_q <= exp_lazy_d;
      done_q     <= done_d;
      succ_cnt_q <= succ_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      lazy_cnt_q <= lazy_cnt_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign a         = a_q;
  assign b         = b_q;
  assign c         = c_q;
  assign exp_succ  = exp_succ_q;
  assign exp_fail  = exp_fail_q;
  assign exp_lazy  = exp_lazy_q;
  assign succ_cnt  = succ_cnt_q;
  assign fail_cnt  = fail_cnt_q;
  assign lazy_cnt  = lazy_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sva_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sva_stim_gen
// Purpose  : Self-checking bench for sva_stim_gen. Counters are built 2 bits
//            wide so saturation is reachable with short commands.
// Revision : 1.0  initial release
// ============================================================================
module tb_sva_stim_gen;

  localparam int LEN_W = 8;
  localparam int CNT_W = 2;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             step = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_mode = 3'd0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             a, b, c;
  logic             exp_succ, exp_fail, exp_lazy;
  logic             busy, done;
  logic [CNT_W-1:0] succ_cnt, fail_cnt, lazy_cnt;

  int checks = 0;
  int errors = 0;

  sva_stim_gen #(.LEN_W(LEN_W), .CNT_W(CNT_W), .SEED(16'hACE1)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .step     (step),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_mode (cmd_mode),
    .cmd_len  (cmd_len),
    .a        (a),
    .b        (b),
    .c        (c),
    .exp_succ (exp_succ),
    .exp_fail (exp_fail),
    .exp_lazy (exp_lazy),
    .busy     (busy),
    .done     (done),
    .succ_cnt (succ_cnt),
    .fail_cnt (fail_cnt),
    .lazy_cnt (lazy_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]       mode;
    logic [LEN_W-1:0] len;
    int               nsteps;
    logic [2:0]       abc;   // {a,b,c} after the final step
    logic [CNT_W-1:0] s, f, l;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // All tasks enter and leave at a falling edge
  task automatic do_reset();
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic accept(input logic [2:0] m, input logic [LEN_W-1:0] n);
    check("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_len   = n;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1;
    @(negedge sys_clk);
    step = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin seen = 1; break; end
      @(negedge sys_clk);
    end
    check(name, 32'(seen), 32'd1);
    @(negedge sys_clk);
  endtask

  initial begin
    logic [15:0] lfsr;
    logic        pend, np, phb, ea, eb, ec, es, ef, el;
    int          rep, budget;

    vecs[0] = '{3'd0, 8'd3, 3, 3'b011, 2'd3, 2'd0, 2'd0};  // PASS1
    vecs[1] = '{3'd1, 8'd2, 2, 3'b000, 2'd0, 2'd0, 2'd2};  // LAZY
    vecs[2] = '{3'd2, 8'd1, 2, 3'b010, 2'd1, 2'd0, 2'd1};  // PASS2
    vecs[3] = '{3'd3, 8'd1, 1, 3'b001, 2'd0, 2'd1, 2'd0};  // FAIL0
    vecs[4] = '{3'd4, 8'd2, 4, 3'b000, 2'd0, 2'd2, 2'd2};  // FAIL1
    vecs[5] = '{3'd6, 8'd1, 1, 3'b000, 2'd0, 2'd0, 2'd1};  // 6 = LAZY
    vecs[6] = '{3'd7, 8'd2, 2, 3'b000, 2'd0, 2'd0, 2'd2};  // 7 = LAZY
    vecs[7] = '{3'd2, 8'd2, 4, 3'b010, 2'd2, 2'd0, 2'd2};  // PASS2 x2
    vecs[8] = '{3'd1, 8'd5, 5, 3'b000, 2'd0, 2'd0, 2'd3};  // saturation

    @(negedge sys_clk);
    do_reset();
    // Reset state
    check("rst_abc", 32'({a, b, c}), 32'd0);
    check("rst_exp", 32'({exp_succ, exp_fail, exp_lazy}), 32'd0);
    check("rst_busy_done_ready", 32'({busy, done, cmd_ready}), 32'b001);
    check("rst_cnts", 32'({succ_cnt, fail_cnt, lazy_cnt}), 32'd0);

    // Table-driven commands
    for (int v = 0; v < 9; v++) begin
      do_reset();
      accept(vecs[v].mode, vecs[v].len);
      for (int s = 0; s < vecs[v].nsteps; s++) begin
        check($sformatf("v%0d_busy_step%0d", v, s), 32'(busy), 32'd1);
        do_step();
      end
      wait_done($sformatf("v%0d_done", v));
      check($sformatf("v%0d_abc", v), 32'({a, b, c}), 32'(vecs[v].abc));
      check($sformatf("v%0d_succ_cnt", v), 32'(succ_cnt), 32'(vecs[v].s));
      check($sformatf("v%0d_fail_cnt", v), 32'(fail_cnt), 32'(vecs[v].f));
      check($sformatf("v%0d_lazy_cnt", v), 32'(lazy_cnt), 32'(vecs[v].l));
      check($sformatf("v%0d_idle", v), 32'({busy, cmd_ready}), 32'b01);
    end

    // PASS2 step by step
    do_reset();
    accept(3'd2, 8'd1);
    do_step();
    check("pass2_s1_abc", 32'({a, b, c}), 32'b101);
    check("pass2_s1_flags", 32'({exp_succ, exp_fail, exp_lazy}), 32'b000);
    do_step();
    check("pass2_s2_abc", 32'({a, b, c}), 32'b010);
    check("pass2_s2_flags", 32'({exp_succ, exp_fail, exp_lazy}), 32'b101);
    @(negedge sys_clk);
    check("pass2_flags_pulse", 32'({exp_succ, exp_fail, exp_lazy}), 32'b000);
    check("pass2_abc_hold", 32'({a, b, c}), 32'b010);

    // Zero-length command: done two cycles after accept, nothing driven
    do_reset();
    accept(3'd0, 8'd0);
    check("len0_c1", 32'({done, busy}), 32'b01);
    @(negedge sys_clk);
    check("len0_c2", 32'({done, busy}), 32'b10);
    @(negedge sys_clk);
    check("len0_c3", 32'({done, busy}), 32'b00);
    check("len0_abc", 32'({a, b, c}), 32'd0);
    check("len0_cnts", 32'({succ_cnt, fail_cnt, lazy_cnt}), 32'd0);

    // Reset between PASS2 steps clears pending attempt
    do_reset();
    accept(3'd2, 8'd1);
    do_step();
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("midrst_abc_exp", 32'({a, b, c, exp_succ, exp_fail, exp_lazy}), 32'd0);
    check("midrst_ctrl", 32'({busy, done, cmd_ready}), 32'b001);
    do_step();
    check("midrst_idle_step", 32'({exp_succ, exp_fail, exp_lazy}), 32'b001);

    // Accept coincident with step; command fields changed while busy
    do_reset();
    cmd_valid = 1'b1;
    cmd_mode  = 3'd0;
    cmd_len   = 8'd1;
    step      = 1'b1;
    @(negedge sys_clk);
    cmd_mode  = 3'd3;
    cmd_len   = 8'd9;
    step      = 1'b0;
    check("coinc_abc", 32'({a, b, c}), 32'd0);
    check("coinc_flags", 32'({exp_succ, exp_fail, exp_lazy}), 32'b001);
    check("coinc_busy", 32'(busy), 32'd1);
    do_step();
    cmd_valid = 1'b0;
    check("coinc_step_abc", 32'({a, b, c}), 32'b011);
    check("coinc_step_flags", 32'({exp_succ, exp_fail, exp_lazy}), 32'b100);
    wait_done("coinc_done");

    // RANDOM against an independent software model from SEED
    do_reset();
    accept(3'd5, 8'd40);
    lfsr = 16'hACE1; pend = 1'b0; phb = 1'b0; rep = 40; budget = 200;
    while (rep != 0 && budget > 0) begin
      budget--;
      {ea, eb, ec} = lfsr[2:0];
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      es = 1'b0; ef = 1'b0; el = 1'b0; np = 1'b0;
      if (pend) begin
        if (eb) es = 1'b1; else ef = 1'b1;
      end
      if (ec && eb)  es = 1'b1;
      else if (!ec)  el = 1'b1;
      else if (ea)   np = 1'b1;
      else           ef = 1'b1;
      pend = np;
      do_step();
      check("rand_abc", 32'({a, b, c}), 32'({ea, eb, ec}));
      check("rand_flags", 32'({exp_succ, exp_fail, exp_lazy}), 32'({es, ef, el}));
      if (!phb && ec && ea && !eb) phb = 1'b1;
      else begin phb = 1'b0; rep--; end
    end
    check("rand_budget", 32'(rep), 32'd0);
    wait_done("rand_done");
    // Step in IDLE resolves any attempt left open by the last random pattern
    do_step();
    check("rand_idle_step", 32'({exp_succ, exp_fail, exp_lazy}), 32'({1'b0, pend, 1'b1}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
